// File: rtl/neuron_activate.sv
// Neuron activation stage: counts TAPS MAC steps, captures the accumulator and bias,
// pulses the MAC clear, then presents ReLU(((acc + bias) >> SHIFT)) saturated to 8 bits.
// Optional: define NEURON_ROUND_EN to round half up before the shift instead of truncating.
module neuron_activate #(
  parameter int TAPS  = 9,
  parameter int SHIFT = 8
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              step,
  input  logic [16:0]       acc_in,
  input  logic signed [9:0] bias,
  output logic              mac_clear_n,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  typedef enum logic [1:0] {ACCUM, CAPTURE, CLEAR, HOLD} state_t;

  localparam logic [7:0] LAST_STEP = 8'(TAPS - 1);

  state_t             state;
  logic [7:0]         count;
  logic [16:0]        acc_q;
  logic signed [9:0]  bias_q;

  // 20 bits: the largest accumulator plus the largest bias does not fit in 18.
  logic signed [19:0] sum;
  logic signed [19:0] biased;
  logic signed [19:0] quot;
  logic [7:0]         act;

`ifdef NEURON_ROUND_EN
  localparam logic signed [19:0] HALF = 20'sd1 <<< (SHIFT - 1);
`endif

  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    sum = $signed({3'b000, acc_q}) + $signed({{10{bias_q[9]}}, bias_q});
`ifdef NEURON_ROUND_EN
    biased = sum + HALF;
`else
    biased = sum;
`endif
    quot = biased >>> SHIFT;
    if (sum < 0)
      act = 8'h00;
    else if (quot > 20'sd255)
      act = 8'hFF;
    else
      act = quot[7:0];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state       <= ACCUM;
      count       <= '0;
      acc_q       <= '0;
      bias_q      <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      mac_clear_n <= 1'b0;
    end else begin
      // The MAC clear is low only for the single cycle spent in CLEAR.
      mac_clear_n <= 1'b1;
      unique case (state)
        ACCUM: begin
          if (step) begin
            if (count == LAST_STEP) begin
              count <= '0;
              state <= CAPTURE;
            end else begin
              count <= count + 8'd1;
            end
          end
        end
        CAPTURE: begin
          acc_q       <= acc_in;
          bias_q      <= bias;
          mac_clear_n <= 1'b0;
          state       <= CLEAR;
        end
        CLEAR: begin
          out_data  <= act;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign busy = (state != ACCUM);

endmodule
